controle_ataque: RTL and testbench

- Attack-phase controller for the battleship game; the input-side counterpart of the LED-matrix driver.
- Takes a coordinate from the switches and a raw confirm button, then checks the shot against the confirmed fleet map (mapa0..mapa4).
- Maintains the shot/hit history and produces the five 7-bit column maps the matrix driver scans, plus hit and attempt counts and end-of-game flags.
- Instantiated in the top level, enabled by the ATAQUE state, clocked from the divided clock.

---
 rtl/jogo_pkg.sv | 7 +
 rtl/debounce_botao.sv | 34 +++
 rtl/controle_ataque.sv | 116 +++++++++++
 tb/tb_controle_ataque.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// jogo_pkg: shared board geometry, FSM encoding and column map type for the battleship game.
package jogo_pkg;
    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;
    typedef enum logic [1:0] {JOGANDO, AVALIA, CHECA, FIM} estado_t;
    typedef logic [NUM_LINHAS-1:0] coluna_t;
endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: two-flop synchronizer, debounce counter and one-cycle press pulse for an active-low button.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic nivel,
    output logic pressionado
);
    localparam int W = $clog2(DEBOUNCE_CICLOS + 1);
    logic s1, s2;
    logic [W-1:0] cnt;
    // The pulse fires only on the 1->0 transition of the accepted level.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            nivel <= 1'b1;
            cnt <= '0;
            pressionado <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            pressionado <= 1'b0;
            if (s2 == nivel) cnt <= '0;
            else if (cnt == W'(DEBOUNCE_CICLOS - 1)) begin
                nivel <= s2;
                cnt <= '0;
                pressionado <= nivel;
            end else cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/controle_ataque.sv
// controle_ataque: attack-phase controller; validates shots against the fleet map,
// keeps shot/hit history and drives the five column maps for the matrix display.
module controle_ataque
    import jogo_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int MAX_TENTATIVAS  = 15,
    parameter int PISCA_BITS      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_confirmar,
    input  logic [2:0] coluna,
    input  logic [2:0] linha,
    input  coluna_t    mapa0,
    input  coluna_t    mapa1,
    input  coluna_t    mapa2,
    input  coluna_t    mapa3,
    input  coluna_t    mapa4,
    output coluna_t    matriz0,
    output coluna_t    matriz1,
    output coluna_t    matriz2,
    output coluna_t    matriz3,
    output coluna_t    matriz4,
    output logic [5:0] acertos,
    output logic [5:0] tentativas,
    output logic       ultimo_acerto,
    output logic       ultimo_erro,
    output logic       jogada_invalida,
    output logic       vitoria,
    output logic       derrota
);
    localparam int N = NUM_COLUNAS * NUM_LINHAS;
    estado_t estado;
    logic [PISCA_BITS-1:0] pisca;
    logic [N-1:0] mapa_v, tiro, acerto, cursor, vis;
    logic [2:0] col_l, lin_l;
    logic [5:0] idx_l, idx_c;
    logic fora_l, fora_c, fase, ganhou, pressionado, nivel;
    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debounce (
        .clock(clock),
        .reset(reset),
        .btn(btn_confirmar),
        .nivel(nivel),
        .pressionado(pressionado)
    );
    // Flattened cell index is coluna*7 + linha, matching the mapa/matriz bit layout.
    assign mapa_v = {mapa4, mapa3, mapa2, mapa1, mapa0};
    assign idx_l  = 6'(col_l) * 6'd7 + 6'(lin_l);
    assign idx_c  = 6'(coluna) * 6'd7 + 6'(linha);
    assign fora_l = col_l > 3'd4 || lin_l > 3'd6;
    assign fora_c = coluna > 3'd4 || linha > 3'd6;
    assign fase   = pisca[PISCA_BITS-1];
    assign ganhou = (|mapa_v) && ((acerto & mapa_v) == mapa_v);
    assign cursor = fora_c ? '0 : (N'(fase) << idx_c);
    assign vis    = !enable ? '0 : estado == FIM ? (acerto | mapa_v) : ((acerto | (tiro & {N{fase}})) ^ cursor);
    assign matriz0 = vis[0 +: NUM_LINHAS];
    assign matriz1 = vis[7 +: NUM_LINHAS];
    assign matriz2 = vis[14 +: NUM_LINHAS];
    assign matriz3 = vis[21 +: NUM_LINHAS];
    assign matriz4 = vis[28 +: NUM_LINHAS];
    always_ff @(posedge clock) begin
        if (reset) pisca <= '0;
        else pisca <= pisca + PISCA_BITS'(1);
    end
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            estado <= JOGANDO;
            col_l <= '0;
            lin_l <= '0;
            tiro <= '0;
            acerto <= '0;
            acertos <= '0;
            tentativas <= '0;
            ultimo_acerto <= 1'b0;
            ultimo_erro <= 1'b0;
            jogada_invalida <= 1'b0;
            vitoria <= 1'b0;
            derrota <= 1'b0;
        end else begin
            jogada_invalida <= 1'b0;
            case (estado)
                JOGANDO: if (pressionado) begin
                    col_l <= coluna;
                    lin_l <= linha;
                    estado <= AVALIA;
                end
                AVALIA: begin
                    if (fora_l || tiro[idx_l]) jogada_invalida <= 1'b1;
                    else begin
                        tiro[idx_l] <= 1'b1;
                        tentativas <= tentativas + 6'd1;
                        ultimo_acerto <= mapa_v[idx_l];
                        ultimo_erro <= !mapa_v[idx_l];
                        if (mapa_v[idx_l]) begin
                            acerto[idx_l] <= 1'b1;
                            acertos <= acertos + 6'd1;
                        end
                    end
                    estado <= CHECA;
                end
                CHECA: begin
                    if (ganhou) begin
                        vitoria <= 1'b1;
                        estado <= FIM;
                    end else if (tentativas == 6'(MAX_TENTATIVAS)) begin
                        derrota <= 1'b1;
                        estado <= FIM;
                    end else estado <= JOGANDO;
                end
                FIM: estado <= FIM;
            endcase
        end
    end
endmodule

// File: tb/tb_controle_ataque.sv
// tb_controle_ataque: scoreboard bench; a game-level model predicts each shot result, a monitor checks it.
module tb_controle_ataque;
    localparam int MAXT = 3;
    localparam int DEB  = 16;
    typedef struct {
        bit inv;
        int tent;
        int acs;
        bit ua;
        bit ue;
        bit vit;
        bit der;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic btn = 1'b1;
    logic [2:0] coluna = 3'd7;
    logic [2:0] linha = 3'd7;
    logic [6:0] mapa [5];
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic [5:0] acertos, tentativas;
    logic ultimo_acerto, ultimo_erro, jogada_invalida, vitoria, derrota;
    int tests = 0;
    int fails = 0;
    exp_t q[$];
    bit tiro_m [5][7];
    int tent_m, acs_m;
    bit ua_m, ue_m, fim_m;
    controle_ataque #(.DEBOUNCE_CICLOS(DEB), .MAX_TENTATIVAS(MAXT), .PISCA_BITS(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .btn_confirmar(btn),
        .coluna(coluna), .linha(linha),
        .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
        .matriz0(matriz0), .matriz1(matriz1), .matriz2(matriz2), .matriz3(matriz3), .matriz4(matriz4),
        .acertos(acertos), .tentativas(tentativas), .ultimo_acerto(ultimo_acerto),
        .ultimo_erro(ultimo_erro), .jogada_invalida(jogada_invalida),
        .vitoria(vitoria), .derrota(derrota)
    );
    always #5 clock = ~clock;
    task automatic chk(string nome, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    function automatic int navios();
        int n = 0;
        for (int c = 0; c < 5; c++)
            for (int l = 0; l < 7; l++) n += int'(mapa[c][l]);
        return n;
    endfunction
    task automatic novo_jogo();
        for (int c = 0; c < 5; c++)
            for (int l = 0; l < 7; l++) tiro_m[c][l] = 1'b0;
        tent_m = 0;
        acs_m = 0;
        ua_m = 1'b0;
        ue_m = 1'b0;
        fim_m = 1'b0;
    endtask
    task automatic set_mapa(logic [6:0] m0, logic [6:0] m1, logic [6:0] m2, logic [6:0] m3, logic [6:0] m4);
        mapa[0] = m0;
        mapa[1] = m1;
        mapa[2] = m2;
        mapa[3] = m3;
        mapa[4] = m4;
    endtask
    task automatic atirar(int c, int l);
        exp_t e;
        coluna = 3'(c);
        linha = 3'(l);
        if (!fim_m) begin
            e = '{default: 0};
            if (c > 4 || l > 6 || tiro_m[c][l]) e.inv = 1'b1;
            else begin
                tiro_m[c][l] = 1'b1;
                tent_m++;
                if (mapa[c][l]) begin
                    acs_m++;
                    ua_m = 1'b1;
                    ue_m = 1'b0;
                end else begin
                    ua_m = 1'b0;
                    ue_m = 1'b1;
                end
                e.vit = navios() > 0 && acs_m == navios();
                e.der = !e.vit && tent_m == MAXT;
                fim_m = e.vit || e.der;
            end
            e.tent = tent_m;
            e.acs = acs_m;
            e.ua = ua_m;
            e.ue = ue_m;
            q.push_back(e);
        end
        btn = 1'b0;
        tick(20);
        btn = 1'b1;
        tick(24);
    endtask
    task automatic chk_zeros(string nome);
        chk({nome, "_tent"}, tentativas, 0);
        chk({nome, "_acertos"}, acertos, 0);
        chk({nome, "_flags"}, {ultimo_acerto, ultimo_erro, jogada_invalida, vitoria, derrota}, 0);
        chk({nome, "_matriz"}, int'(|{matriz0, matriz1, matriz2, matriz3, matriz4}), 0);
    endtask
    task automatic reinicia();
        enable = 1'b0;
        tick(1);
        chk_zeros("enable_low");
        set_mapa(0, 0, 0, 0, 0);
        tick(1);
        enable = 1'b1;
        tick(2);
        novo_jogo();
        chk("fresh_tent", tentativas, 0);
    endtask
    // Monitor: a change of tentativas or an invalid pulse is one shot result.
    initial begin
        int prev = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (enable && !reset && (jogada_invalida || int'(tentativas) != prev)) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got tentativas=%0d invalida=%0d expected no result", tentativas, jogada_invalida);
                end else begin
                    e = q.pop_front();
                    chk("invalida", jogada_invalida, e.inv);
                    chk("tentativas", tentativas, e.tent);
                    chk("acertos", acertos, e.acs);
                    chk("ultimo_acerto", ultimo_acerto, e.ua);
                    chk("ultimo_erro", ultimo_erro, e.ue);
                    chk("fim_early", {vitoria, derrota}, 0);
                    @(negedge clock);
                    chk("vitoria", vitoria, e.vit);
                    chk("derrota", derrota, e.der);
                    chk("invalida_pulse", jogada_invalida, 0);
                end
            end
            prev = tentativas;
        end
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bit seen0, seen1, hit_ok, vazio_ok;
        int c, l;
        set_mapa(0, 0, 0, 0, 0);
        novo_jogo();
        enable = 1'b1;
        tick(3);
        chk_zeros("reset");
        reset = 1'b0;
        tick(2);
        // single-ship fleet: one hit wins
        reinicia();
        set_mapa(0, 0, 7'b0000100, 0, 0);
        tick(2);
        atirar(2, 2);
        chk("t1_matriz2_2", matriz2[2], 1);
        chk("t1_vitoria", vitoria, 1);
        reinicia();
        // miss, repeat, out-of-range, bounce
        set_mapa(0, 0, 0, 7'b1000001, 0);
        atirar(0, 0);
        atirar(0, 0);
        atirar(5, 0);
        atirar(1, 7);
        repeat (8) begin
            btn = 1'b0;
            tick(1);
            btn = 1'b1;
            tick(3);
        end
        tick(40);
        chk("t4_bounce_tent", tentativas, 1);
        reinicia();
        // exhaust attempts, then a further press is ignored
        set_mapa(0, 0, 0, 0, 7'b1111111);
        atirar(0, 1);
        atirar(1, 1);
        atirar(2, 1);
        atirar(3, 3);
        chk("t5_tent", tentativas, 3);
        chk("t5_derrota", derrota, 1);
        chk("t5_fim_m4", matriz4, 7'h7f);
        chk("t5_fim_m0", matriz0, 0);
        reinicia();
        // two hits, display and cursor behaviour, then drop enable
        set_mapa(0, 7'b0000111, 0, 0, 0);
        atirar(1, 0);
        atirar(1, 1);
        chk("t6_acertos", acertos, 2);
        coluna = 3'd1;
        linha = 3'd5;
        seen0 = 0;
        seen1 = 0;
        hit_ok = 1;
        vazio_ok = 1;
        repeat (300) begin
            tick(1);
            if (matriz1[5]) seen1 = 1; else seen0 = 1;
            hit_ok &= matriz1[0] & matriz1[1];
            vazio_ok &= !matriz1[2] && matriz0 == 0;
        end
        chk("t6_cursor_blinks", int'(seen0 && seen1), 1);
        chk("t6_hits_on", hit_ok, 1);
        chk("t6_unshot_off", vazio_ok, 1);
        reinicia();
        // randomized games against the model
        repeat (12) begin
            set_mapa(7'($urandom & $urandom & $urandom), 7'($urandom & $urandom & $urandom),
                     7'($urandom & $urandom & $urandom), 7'($urandom & $urandom & $urandom),
                     7'($urandom & $urandom & $urandom));
            if ($urandom_range(0, 5) == 0) set_mapa(0, 0, 0, 0, 0);
            for (int s = 0; s < 6 && !fim_m; s++) begin
                c = $urandom_range(0, 7);
                l = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1)
                    for (int k = 0; k < 30; k++) begin
                        c = $urandom_range(0, 4);
                        l = $urandom_range(0, 6);
                        if (mapa[c][l]) break;
                    end
                atirar(c, l);
            end
            if (fim_m) begin
                chk("fim_m0", matriz0, mapa[0]);
                chk("fim_m1", matriz1, mapa[1]);
                chk("fim_m2", matriz2, mapa[2]);
                chk("fim_m3", matriz3, mapa[3]);
                chk("fim_m4", matriz4, mapa[4]);
            end
            reinicia();
        end
        tick(50);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
